// File: rtl/delta_decoder.sv
// delta_decoder: rebuilds an N-bit value stream from a seed plus signed deltas
// (magnitude + direction), with a one-deep valid/ready output register.
// Optional feature macro: DELTA_DECODER_SAT_EN -- clamp out-of-range results
// instead of wrapping them modulo 2^N. OVF sets in both builds.
module delta_decoder #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         SEED_VALID,
  input  logic [N-1:0] SEED,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] MAG,
  input  logic         DIR,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] Y,
  output logic         OVF
);

  localparam int unsigned SW = N + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_nxt;
  logic [N-1:0]   y_nxt;
  logic           out_valid_nxt;
  logic           ovf_nxt;
  logic [SW-1:0]  sum_c;
  logic           range_err_c;
  logic [N-1:0]   result_c;
  logic           accept_c;

  // Ready only while running, not being re-seeded, and the output slot frees up.
  assign IN_READY = (state == RUN) & ~SEED_VALID & (~OUT_VALID | OUT_READY);
  assign accept_c = IN_VALID & IN_READY;

  // Extended add/subtract; the top bit flags carry-out or borrow (MAG > ACC).
  always_comb begin
    sum_c = '0;
    if (DIR) begin
      sum_c = SW'({1'b0, acc}) + SW'({1'b0, MAG});
    end else begin
      sum_c = SW'({1'b0, acc}) - SW'({1'b0, MAG});
    end
    range_err_c = sum_c[N];
  end

  // Out-of-range handling: clamp to the violated bound, or keep the low N bits.
  always_comb begin
    result_c = sum_c[N-1:0];
`ifdef DELTA_DECODER_SAT_EN
    if (range_err_c) begin
      result_c = DIR ? {N{1'b1}} : {N{1'b0}};
    end
`endif
  end

  // Next-state and next-register values; seed takes priority over any delta.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    y_nxt         = Y;
    out_valid_nxt = OUT_VALID;
    ovf_nxt       = OVF;
    case (state)
      IDLE: begin
        if (SEED_VALID) begin
          state_nxt     = RUN;
          acc_nxt       = SEED;
          out_valid_nxt = 1'b0;
          ovf_nxt       = 1'b0;
        end
      end
      RUN: begin
        if (SEED_VALID) begin
          acc_nxt       = SEED;
          out_valid_nxt = 1'b0;
          ovf_nxt       = 1'b0;
        end else if (accept_c) begin
          acc_nxt       = result_c;
          y_nxt         = result_c;
          out_valid_nxt = 1'b1;
          if (range_err_c) begin
            ovf_nxt = 1'b1;
          end
        end else if (OUT_VALID && OUT_READY) begin
          out_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers; reset drops any pending output.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc       <= '0;
      Y         <= '0;
      OUT_VALID <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      Y         <= y_nxt;
      OUT_VALID <= out_valid_nxt;
      OVF       <= ovf_nxt;
    end
  end

endmodule
